// File: rtl/uart_hex_cmd_pkg.sv
// Shared constants, parser states and ASCII/hex helpers
// for the UART hex set-command endpoint.
package uart_hex_cmd_pkg;

  localparam int DEF_CLK_FREQ = 12000000;
  localparam int DEF_BAUD     = 115200;
  localparam int VALUE_W      = 12;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  localparam int CLKS_PER_BIT =
    clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);

  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_LS = 8'h73;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [2:0] {
    P_IDLE,
    P_D1,
    P_D2,
    P_D3,
    P_RESP
  } pstate_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rxstate_t;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex2nib(
    input logic [7:0] c
  );
    logic [7:0] v;
    if (c <= 8'h39)      v = c - 8'h30;
    else if (c <= 8'h46) v = c - 8'h37;
    else                 v = c - 8'h57;
    return v[3:0];
  endfunction

  function automatic logic [7:0] nib2asc(
    input logic [3:0] n
  );
    return (n < 4'd10) ? 8'h30 + {4'd0, n}
                       : 8'h37 + {4'd0, n};
  endfunction

endpackage

// File: rtl/uart_hex_cmd_if.sv
// Serial link and value bus between the host side
// and the command endpoint.
interface uart_hex_cmd_if;
  import uart_hex_cmd_pkg::*;

  logic               RX;
  logic               TX;
  logic [VALUE_W-1:0] VALUE;

  modport master (output RX, input TX, VALUE);
  modport slave  (input RX, output TX, VALUE);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop sync, mid-bit sampling,
// glitch reject and framing-error lockout.
module uart_rx
  import uart_hex_cmd_pkg::*;
#(
  parameter int CPB = CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam logic [15:0] LAST = 16'(CPB - 1);
  localparam logic [15:0] HALF = 16'(CPB / 2 - 1);

  logic [1:0]  r_sync;
  logic        r_prev;
  rxstate_t    r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [7:0]  r_shift, w_shift_n;
  logic        r_valid, w_valid_n;
  logic        w_rx;

  assign w_rx    = r_sync[1];
  assign o_valid = r_valid;
  assign o_data  = r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_rx;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_valid <= w_valid_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 16'd1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_valid_n = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        w_cnt_n = '0;
        if (r_prev && !w_rx) w_state_n = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_n   = '0;
          w_shift_n = {w_rx, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_n = '0;
          if (w_rx) begin
            w_valid_n = 1'b1;
            w_state_n = RX_IDLE;
          end else begin
            w_state_n = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        w_cnt_n = '0;
        if (w_rx) w_state_n = RX_IDLE;
      end
      default: w_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; a new byte may be loaded on the
// last stop-bit cycle so frames run back to back.
module uart_tx
  import uart_hex_cmd_pkg::*;
#(
  parameter int CPB = CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_ready
);

  localparam logic [15:0] LAST = 16'(CPB - 1);

  logic        r_busy, w_busy_n;
  logic [9:0]  r_shift, w_shift_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [3:0]  r_bit, w_bit_n;
  logic        r_tx;
  logic        w_last;

  assign w_last  = r_busy && (r_cnt == LAST) &&
                   (r_bit == 4'd9);
  assign o_ready = !r_busy || w_last;
  assign o_busy  = r_busy;
  assign o_tx    = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_shift <= '1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_busy  <= w_busy_n;
      r_shift <= w_shift_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_tx    <= w_busy_n ? w_shift_n[0] : 1'b1;
    end
  end

  always_comb begin
    w_busy_n  = r_busy;
    w_shift_n = r_shift;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    if (i_start && o_ready) begin
      w_busy_n  = 1'b1;
      w_shift_n = {1'b1, i_data, 1'b0};
      w_cnt_n   = '0;
      w_bit_n   = '0;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        w_cnt_n   = '0;
        w_shift_n = {1'b1, r_shift[9:1]};
        w_bit_n   = r_bit + 4'd1;
        if (r_bit == 4'd9) w_busy_n = 1'b0;
      end else begin
        w_cnt_n = r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_hex_cmd.sv
// Hex set-command parser and ack/error responder
// wrapped around the UART receiver and transmitter.
module uart_hex_cmd
  import uart_hex_cmd_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic          CLK,
  input  logic          RST,
  uart_hex_cmd_if.slave bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_tx_start;
  logic [7:0]  w_tx_data;
  logic        w_tx_ready;
  logic        w_tx_busy;
  logic        w_tx;

  pstate_t     r_state, w_state_n;
  logic [11:0] r_acc, w_acc_n;
  logic [11:0] r_value, w_value_n;
  logic [2:0]  r_idx, w_idx_n;
  logic        r_err, w_err_n;

  logic        w_is_s;
  logic        w_is_hex;
  logic [3:0]  w_nib;
  logic [2:0]  w_len;

  uart_rx #(.CPB(CPB)) u_rx (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_rx    (bus.RX),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  uart_tx #(.CPB(CPB)) u_tx (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (w_tx_start),
    .i_data  (w_tx_data),
    .o_tx    (w_tx),
    .o_busy  (w_tx_busy),
    .o_ready (w_tx_ready)
  );

  assign bus.TX    = w_tx;
  assign bus.VALUE = r_value;

  assign w_is_s   = (w_rx_data == ASC_S) ||
                    (w_rx_data == ASC_LS);
  assign w_is_hex = is_hex(w_rx_data);
  assign w_nib    = hex2nib(w_rx_data);
  assign w_len    = r_err ? 3'd3 : 3'd6;

  assign w_tx_start = (r_state == P_RESP) &&
                      (r_idx != w_len) && w_tx_ready;

  // Response bytes are built from VALUE as they go out
  always_comb begin
    w_tx_data = ASC_LF;
    if (r_err) begin
      unique case (r_idx)
        3'd0:    w_tx_data = ASC_E;
        3'd1:    w_tx_data = ASC_CR;
        default: w_tx_data = ASC_LF;
      endcase
    end else begin
      unique case (r_idx)
        3'd0:    w_tx_data = ASC_A;
        3'd1:    w_tx_data = nib2asc(r_value[11:8]);
        3'd2:    w_tx_data = nib2asc(r_value[7:4]);
        3'd3:    w_tx_data = nib2asc(r_value[3:0]);
        3'd4:    w_tx_data = ASC_CR;
        default: w_tx_data = ASC_LF;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= P_IDLE;
      r_acc   <= '0;
      r_value <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_value <= w_value_n;
      r_idx   <= w_idx_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_value_n = r_value;
    w_idx_n   = r_idx;
    w_err_n   = r_err;
    unique case (r_state)
      P_IDLE: begin
        if (w_rx_valid && w_is_s) begin
          w_state_n = P_D1;
          w_acc_n   = '0;
        end
      end
      P_D1, P_D2, P_D3: begin
        if (w_rx_valid) begin
          unique case (1'b1)
            w_is_s: begin
              w_state_n = P_D1;
              w_acc_n   = '0;
            end
            w_is_hex: begin
              w_acc_n = {r_acc[7:0], w_nib};
              unique case (r_state)
                P_D1:    w_state_n = P_D2;
                P_D2:    w_state_n = P_D3;
                default: begin
                  w_value_n = {r_acc[7:0], w_nib};
                  w_idx_n   = '0;
                  w_err_n   = 1'b0;
                  w_state_n = P_RESP;
                end
              endcase
            end
            default: begin
              w_idx_n   = '0;
              w_err_n   = 1'b1;
              w_state_n = P_RESP;
            end
          endcase
        end
      end
      P_RESP: begin
        // Leave only once the final stop bit is out
        if (w_tx_start)
          w_idx_n = r_idx + 3'd1;
        else if (r_idx == w_len && !w_tx_busy)
          w_state_n = P_IDLE;
      end
      default: w_state_n = P_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_hex_cmd.sv
// Directed bench for uart_hex_cmd: host-side serial
// driver, TX frame monitor and expected responses.
`timescale 1ns/1ps
module tb_uart_hex_cmd;

  localparam int CPB = 104;
  localparam int RESP_LIMIT = 7800;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;
  int   mon_bad;
  logic [7:0] rxq[$];

  uart_hex_cmd_if bus();

  uart_hex_cmd dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #41.667 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input logic       stop
  );
    bus.RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.RX = stop;
    repeat (CPB) @(negedge clk);
    bus.RX = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(
    input logic [63:0] s,
    input int          n
  );
    for (int i = 0; i < n; i++)
      send_byte(s[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic expect_resp(
    input string       tag,
    input logic [47:0] exp,
    input int          n
  );
    int t;
    logic [7:0] got;
    t = 0;
    while (rxq.size() < n && t < RESP_LIMIT) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_len"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      chk($sformatf("%s_b%0d", tag, i),
          {24'd0, got}, {24'd0, exp[8*(n-1-i) +: 8]});
    end
    repeat (2 * CPB) @(negedge clk);
    chk({tag, "_extra"}, rxq.size(), 0);
  endtask

  initial begin : tx_monitor
    logic [7:0] b;
    mon_bad = 0;
    forever begin
      @(negedge bus.TX);
      repeat (CPB / 2) @(negedge clk);
      if (bus.TX === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.TX;
        end
        repeat (CPB) @(negedge clk);
        if (bus.TX !== 1'b1) mon_bad++;
        rxq.push_back(b);
      end
    end
  end

  initial begin
    n_err  = 0;
    n_chk  = 0;
    rst    = 1'b1;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", {31'd0, bus.TX}, 1);
    chk("rst_value", {20'd0, bus.VALUE}, 32'h000);
    repeat (12000) @(negedge clk);
    chk("idle_quiet", rxq.size(), 0);
    chk("idle_tx", {31'd0, bus.TX}, 1);

    send_str(64'("S0F7"), 4);
    chk("val_0f7", {20'd0, bus.VALUE}, 32'h0F7);
    expect_resp("ack_0f7", 48'h413046370D0A, 6);

    send_str(64'("S114"), 4);
    chk("val_114", {20'd0, bus.VALUE}, 32'h114);
    expect_resp("ack_114", 48'h413131340D0A, 6);

    send_str(64'("sabc"), 4);
    chk("val_abc", {20'd0, bus.VALUE}, 32'hABC);
    expect_resp("ack_abc", 48'h414142430D0A, 6);

    send_str(64'("S1G"), 3);
    expect_resp("err_1g", 48'h450D0A, 3);
    chk("val_kept", {20'd0, bus.VALUE}, 32'hABC);

    send_str(64'("S12S345"), 7);
    chk("val_345", {20'd0, bus.VALUE}, 32'h345);
    expect_resp("ack_345", 48'h413334350D0A, 6);

    send_str(64'("S1"), 2);
    send_byte(8'h3F, 1'b0);
    send_str(64'("23"), 2);
    chk("val_123", {20'd0, bus.VALUE}, 32'h123);
    expect_resp("ack_123", 48'h413132330D0A, 6);

    send_str(64'("S9"), 2);
    bus.RX = 1'b0;
    repeat (300) @(negedge clk);
    rst    = 1'b1;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    chk("rst_mid_value", {20'd0, bus.VALUE}, 32'h000);
    chk("rst_mid_tx", {31'd0, bus.TX}, 1);
    chk("rst_mid_quiet", rxq.size(), 0);
    chk("tx_stop_bits", mon_bad, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
